// File: rtl/tx_hex_printer.sv
// Prints a latched WIDTH-bit value as "0x<hex digits>\n\r" into tx_pipe, one byte per push_back pulse.
// Optional macro TX_HEX_PRINTER_ZERO_SUPPRESS_EN drops leading zero digits (at least one digit is always printed).
module tx_hex_printer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             push_back,
    output logic [7:0]       data_out,
    input  logic             full
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGIT,
        S_NL,
        S_CR,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             push_q, push_d;
    logic [7:0]       data_q, data_d;

    logic [3:0]       nib;
    logic [7:0]       cur_char;
    logic             skip_now;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    assign nib = sh_q[WIDTH-1 -: 4];

    always_comb begin
        cur_char = 8'h00;
        case (state_q)
            S_PFX0:  cur_char = 8'h30;
            S_PFX1:  cur_char = 8'h78;
            S_DIGIT: cur_char = hex_char(nib);
            S_NL:    cur_char = 8'h0A;
            S_CR:    cur_char = 8'h0D;
            default: cur_char = 8'h00;
        endcase
    end

`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
    logic skip_q, skip_d;

    // Skipping only happens between pushes and never consumes the last digit.
    assign skip_now = skip_q && (state_q == S_DIGIT) && !push_q &&
                      (nib == 4'h0) && (cnt_q > CW'(1));
`else
    assign skip_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        push_d  = push_q;
        data_d  = data_q;
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
        skip_d  = skip_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d    = value;
                    cnt_d   = CW'(NDIG);
                    busy_d  = 1'b1;
                    state_d = S_PFX0;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                if (skip_now) begin
                    sh_d  = sh_q << 4;
                    cnt_d = cnt_q - CW'(1);
                end else if (!push_q) begin
                    // Cycle A: issue a push only when tx_pipe has room.
                    if (!full) begin
                        push_d = 1'b1;
                        data_d = cur_char;
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
                        skip_d = 1'b0;
`endif
                    end
                end else begin
                    push_d = 1'b0;
                    case (state_q)
                        S_PFX0: state_d = S_PFX1;
                        S_PFX1: begin
                            state_d = S_DIGIT;
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
                            skip_d  = 1'b1;
`endif
                        end
                        S_DIGIT: begin
                            sh_d  = sh_q << 4;
                            cnt_d = cnt_q - CW'(1);
                            if (cnt_q == CW'(1))
                                state_d = S_NL;
                        end
                        S_NL:    state_d = S_CR;
                        S_CR:    state_d = S_FIN;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            push_q  <= 1'b0;
            data_q  <= 8'h00;
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            push_q  <= push_d;
            data_q  <= data_d;
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
            skip_q  <= skip_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign push_back = push_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_tx_hex_printer.sv
// Directed bench for tx_hex_printer: captures every pushed byte and compares whole lines against literal text.
module tb_tx_hex_printer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        full = 1'b0;
    logic [31:0] value = 32'h0;
    logic        busy, done, push_back;
    logic [7:0]  data_out;

    always #5 clk = ~clk;

    tx_hex_printer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .push_back(push_back),
        .data_out (data_out),
        .full     (full)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int viol = 0;
    logic prev_push = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Byte capture plus push_back protocol watch (no back-to-back pulses, no push while full).
    always @(posedge clk) begin
        #1;
        if (push_back) begin
            got_q.push_back(data_out);
            if (prev_push) viol++;
            if (full) viol++;
        end
        if (done) done_cnt++;
        prev_push = push_back;
    end

    task automatic add_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
    endtask

    // Called at a negedge; returns one negedge later with start dropped.
    task automatic start_line(input logic [31:0] v);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || push_back !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b push=%b data=%h, want 0 0 0 00",
                     busy, done, push_back, data_out);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || push_back !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b push=%b, want 0 0", busy, push_back);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        exp_q.delete();
        got_q.delete();
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
        add_exp("0xAF");
`else
        add_exp("0x000000AF");
`endif
        d0 = done_cnt;
        viol = 0;
        start_line(32'h0000_00AF);
        total++;
        if (busy !== 1'b1 || push_back !== 1'b0) begin
            bad++;
            $display("FAIL basic_accept: busy=%b push=%b, want 1 0", busy, push_back);
        end
        @(negedge clk);
        total++;
        if (push_back !== 1'b1 || data_out !== 8'h30) begin
            bad++;
            $display("FAIL basic_first_push: push=%b data=%h, want 1 30", push_back, data_out);
        end
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout: done not seen");
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL basic_len: got %0d bytes, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_byte[%0d]: got %h, want %h", i, g, exp_q[i]);
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 != 1 || viol != 0) begin
            bad++;
            $display("FAIL basic_end: busy=%b done=%b dones=%0d viol=%0d, want 0 0 1 0",
                     busy, done, done_cnt - d0, viol);
        end
        $display("basic line: %0d bytes", got_q.size());
    endtask

    task automatic test_values();
        logic [31:0] vals[2];
        string       strs[2];
        bit ok;
        vals[0] = 32'h0000_0000;
        vals[1] = 32'hDEAD_BEEF;
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
        strs[0] = "0x0";
`else
        strs[0] = "0x00000000";
`endif
        strs[1] = "0xDEADBEEF";
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            got_q.delete();
            add_exp(strs[k]);
            start_line(vals[k]);
            wait_done(ok);
            total++;
            if (!ok || got_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL value_len %h: ok=%0d got %0d bytes, want %0d",
                         vals[k], ok, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                logic [7:0] g;
                g = (i < got_q.size()) ? got_q[i] : 8'hxx;
                total++;
                if (g !== exp_q[i]) begin
                    bad++;
                    $display("FAIL value_byte %h [%0d]: got %h, want %h", vals[k], i, g, exp_q[i]);
                end
            end
            $display("value %h line: %0d bytes", vals[k], got_q.size());
            @(negedge clk);
        end
    endtask

    task automatic test_full();
        bit ok;
        bit reached;
        exp_q.delete();
        got_q.delete();
        add_exp("0x12345678");
        viol = 0;
        reached = 1'b0;
        start_line(32'h1234_5678);
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() >= 3) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL full_reach3: only %0d pushes seen", got_q.size());
        end
        full = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (got_q.size() != 3) begin
            bad++;
            $display("FAIL full_hold: got %0d bytes while full, want 3", got_q.size());
        end
        full = 1'b0;
        wait_done(ok);
        total++;
        if (!ok || got_q.size() != exp_q.size() || viol != 0) begin
            bad++;
            $display("FAIL full_len: ok=%0d got %0d bytes want %0d viol=%0d",
                     ok, got_q.size(), exp_q.size(), viol);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL full_byte[%0d]: got %h, want %h", i, g, exp_q[i]);
            end
        end
        $display("full-stall line: %0d bytes", got_q.size());
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int d0;
        exp_q.delete();
        got_q.delete();
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
        add_exp("0xAF");
`else
        add_exp("0x000000AF");
`endif
        d0 = done_cnt;
        start_line(32'h0000_00AF);
        repeat (4) @(negedge clk);
        value = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        repeat (30) @(negedge clk);
        total++;
        if (!ok || done_cnt - d0 != 1 || busy !== 1'b0 || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL busy_ignore: ok=%0d dones=%0d busy=%b bytes=%0d, want 1 1 0 %0d",
                     ok, done_cnt - d0, busy, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL busy_byte[%0d]: got %h, want %h", i, g, exp_q[i]);
            end
        end
        $display("busy-ignore line: %0d bytes", got_q.size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached;
        got_q.delete();
        reached = 1'b0;
        start_line(32'hDEAD_BEEF);
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() >= 5) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (!reached || push_back !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: reached=%0d push=%b busy=%b done=%b, want 1 0 0 0",
                     reached, push_back, busy, done);
        end
        exp_q.delete();
        got_q.delete();
        add_exp("0xDEADBEEF");
        start_line(32'hDEAD_BEEF);
        wait_done(ok);
        total++;
        if (!ok || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL reset_mid_len: ok=%0d got %0d bytes, want %0d",
                     ok, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_mid_byte[%0d]: got %h, want %h", i, g, exp_q[i]);
            end
        end
        $display("post-reset line: %0d bytes", got_q.size());
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3];
        bit ok;
        int d0;
        vals[0] = 32'h00C0_FFEE;
        vals[1] = 32'hCAFE_F00D;
        vals[2] = 32'h0000_0001;
        exp_q.delete();
        got_q.delete();
`ifdef TX_HEX_PRINTER_ZERO_SUPPRESS_EN
        add_exp("0xC0FFEE");
        add_exp("0xCAFEF00D");
        add_exp("0x1");
`else
        add_exp("0x00C0FFEE");
        add_exp("0xCAFEF00D");
        add_exp("0x00000001");
`endif
        d0 = done_cnt;
        viol = 0;
        for (int k = 0; k < 3; k++) begin
            start_line(vals[k]);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_accept[%0d]: busy=%b, want 1", k, busy);
            end
            wait_done(ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL b2b_timeout[%0d]: done not seen", k);
            end
        end
        @(negedge clk);
        total++;
        if (done_cnt - d0 != 3 || got_q.size() != exp_q.size() || viol != 0) begin
            bad++;
            $display("FAIL b2b_summary: dones=%0d bytes=%0d viol=%0d, want 3 %0d 0",
                     done_cnt - d0, got_q.size(), viol, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_byte[%0d]: got %h, want %h", i, g, exp_q[i]);
            end
        end
        $display("back-to-back: %0d bytes over 3 lines", got_q.size());
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_full();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
